// File: rtl/buffer4x16_loader.sv
// Write-side controller for the 4x16 sliding line buffer: streams image rows from memory into
// the buffer and sweeps readIdx over every 4x4 window once four rows are resident.
module buffer4x16_loader #(
  parameter int unsigned IMG_ROWS  = 16,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       buf_data,
  output logic [15:0]       buf_en,
  output logic              buf_shift,
  output logic [3:0]        read_idx,
  output logic              win_valid,
  output logic [3:0]        win_row,
  output logic [3:0]        win_col,
  output logic              win_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned RowW = $clog2(IMG_ROWS);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StScan, StFin} state_e;

  state_e          state_q;
  logic [2:0]      cnt_q;
  logic [RowW-1:0] row_q;

  assign buf_data = mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      row_q     <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      buf_en    <= '0;
      buf_shift <= 1'b0;
      read_idx  <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      win_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      buf_en    <= '0;
      buf_shift <= 1'b0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      done      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StLoad;
            row_q    <= '0;
            cnt_q    <= '0;
            mem_rd   <= 1'b1;
            mem_addr <= ADDR_W'(BASE_ADDR);
            busy     <= 1'b1;
          end
        end
        StLoad: begin
          // Write enable trails its read strobe by one cycle to meet the read data.
          if (cnt_q == 3'd4) begin
            cnt_q <= '0;
            if (row_q < RowW'(3)) begin
              state_q   <= StShift;
              buf_shift <= 1'b1;
            end else begin
              state_q <= StScan;
            end
          end else begin
            cnt_q  <= cnt_q + 3'd1;
            buf_en <= 16'h8000 >> {cnt_q[1:0], 2'b00};
            if (cnt_q != 3'd3) begin
              mem_rd   <= 1'b1;
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
        StShift: begin
          // Address still points at word 3 of the previous row.
          state_q  <= StLoad;
          row_q    <= row_q + RowW'(1);
          mem_rd   <= 1'b1;
          mem_addr <= mem_addr + ADDR_W'(1);
        end
        StScan: begin
          win_valid <= 1'b1;
          win_col   <= read_idx;
          win_row   <= 4'(row_q - RowW'(3));
          if (read_idx == 4'd12) begin
            read_idx <= '0;
            if (row_q == RowW'(IMG_ROWS - 1)) begin
              state_q  <= StFin;
              win_last <= 1'b1;
              done     <= 1'b1;
            end else begin
              state_q   <= StShift;
              buf_shift <= 1'b1;
            end
          end else begin
            read_idx <= read_idx + 4'd1;
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
